// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel, W-bit registered multiplexer with manual select and
// auto-scan modes, a scan prescaler, a hold control and a channel-change strobe.
//
// Optional build macro: MUX_SCAN_BLANK_EN
//   When defined, dout is blanked to zero on the edge that switches channel,
//   so new channel data appears one edge later (anti-ghosting for displays).
module mux_scan_n #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int DIV = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N*W-1:0]           din,
    input  logic [$clog2(N)-1:0]     sel,
    input  logic                     mode,
    input  logic                     hold,
    output logic [W-1:0]             dout,
    output logic [$clog2(N)-1:0]     ch,
    output logic                     strobe
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(DIV);

    // Constants sized to the registers they are compared against.
    localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
    localparam logic [SW-1:0] CH_MAX  = SW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [SW-1:0] r_ch;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dout;
    logic          r_strobe;

    logic [SW-1:0] w_nch;
    logic [CW-1:0] w_ncnt;
    logic [W-1:0]  w_sel_data;
    logic [W-1:0]  w_ndout;
    logic          w_chg;

    // Next channel: hold freezes, manual takes in-range sel, auto advances at prescaler terminal count.
    always_comb begin
        w_nch = r_ch;
        if (!hold) begin
            if (!mode) begin
                if ({1'b0, sel} < N_EXT) begin
                    w_nch = sel;
                end
            end else if (r_cnt == CNT_MAX) begin
                w_nch = (r_ch == CH_MAX) ? '0 : r_ch + 1'b1;
            end
        end
    end

    // Prescaler next value: manual mode clears it even when held, so auto always starts with a full dwell.
    always_comb begin
        w_ncnt = r_cnt;
        if (!mode) begin
            w_ncnt = '0;
        end else if (!hold) begin
            w_ncnt = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
    end

    // Channel data for the next channel, selected by comparison to avoid indexing past N.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_nch == SW'(k)) begin
                w_sel_data = din[k*W +: W];
            end
        end
    end

    assign w_chg = (w_nch != r_ch);

    // Output data next value; blanking build inserts one zero cycle on each channel switch.
    always_comb begin
        w_ndout = w_sel_data;
`ifdef MUX_SCAN_BLANK_EN
        if (w_chg) begin
            w_ndout = '0;
        end
`else
        w_ndout = w_sel_data;
`endif
    end

    // State register: channel, prescaler, output data and strobe all load together so ch and dout stay consistent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch     <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_ch     <= w_nch;
            r_cnt    <= w_ncnt;
            r_dout   <= w_ndout;
            r_strobe <= w_chg;
        end
    end

    assign dout   = r_dout;
    assign ch     = r_ch;
    assign strobe = r_strobe;

endmodule

// File: tb/tb_mux_scan_n.sv
// Testbench for mux_scan_n: table-driven manual-mode vectors plus hand-written
// auto-scan, hold, mode-switch, out-of-range select and blanking sequences.
module tb_mux_scan_n;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;
    logic [7:0]  dout;
    logic [1:0]  ch;
    logic        strobe;
    logic [7:0]  dout3;
    logic [1:0]  ch3;
    logic        strobe3;

    int n_vec;
    int n_miss;

    mux_scan_n #(.W(8), .N(4), .DIV(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
        .hold(hold), .dout(dout), .ch(ch), .strobe(strobe)
    );

    mux_scan_n #(.W(8), .N(3), .DIV(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .din(din[23:0]), .sel(sel), .mode(mode),
        .hold(hold), .dout(dout3), .ch(ch3), .strobe(strobe3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic        hold;
        logic [1:0]  sel;
        logic [31:0] din;
        logic [1:0]  ch;
        logic [7:0]  dout;
        logic        strobe;
    } vec_t;

    vec_t vt[13];

    // Expected dout given the unblanked channel data and whether this is a strobe cycle.
    function automatic logic [7:0] exp_d(input logic [7:0] d, input logic st);
`ifdef MUX_SCAN_BLANK_EN
        return st ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [7:0] chan(input logic [31:0] d, input logic [1:0] c);
        logic [31:0] t;
        t = d >> (c * 8);
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then check ch, strobe and dout of the N=4 instance.
    task automatic step_chk(input string name, input logic [1:0] ec, input logic es);
        tick();
        chk({name, ".ch"}, {6'd0, ch}, {6'd0, ec});
        chk({name, ".strobe"}, {7'd0, strobe}, {7'd0, es});
        chk({name, ".dout"}, dout, exp_d(chan(din, ec), es));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        //            rst  mode hold sel din           ch   dout   strobe
        vt[0]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h44332211, 2'd0, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h44332211, 2'd0, 8'h00, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h44332211, 2'd0, 8'h00, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h44332211, 2'd2, 8'h33, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h44332211, 2'd2, 8'h33, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h44AA2211, 2'd2, 8'hAA, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h44332211, 2'd0, 8'h11, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 2'd3, 32'h44332211, 2'd3, 8'h44, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h44332211, 2'd3, 8'h44, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h55332211, 2'd3, 8'h55, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h44332211, 2'd1, 8'h22, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h44332211, 2'd0, 8'h00, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h44332211, 2'd1, 8'h22, 1'b1};

        rst_n = 1'b0;
        mode  = 1'b1;
        hold  = 1'b0;
        sel   = 2'd0;
        din   = 32'h44332211;

        for (int i = 0; i < 13; i++) begin
            rst_n = vt[i].rst_n;
            mode  = vt[i].mode;
            hold  = vt[i].hold;
            sel   = vt[i].sel;
            din   = vt[i].din;
            tick();
            chk($sformatf("vec%0d.ch", i), {6'd0, ch}, {6'd0, vt[i].ch});
            chk($sformatf("vec%0d.strobe", i), {7'd0, strobe}, {7'd0, vt[i].strobe});
            chk($sformatf("vec%0d.dout", i), dout,
                (vt[i].rst_n == 1'b0) ? 8'h00 : exp_d(vt[i].dout, vt[i].strobe));
        end

        // N=3 instance: in-range select, then out-of-range select is ignored.
        sel = 2'd2;
        tick();
        chk("n3.sel2.ch", {6'd0, ch3}, 8'd2);
        sel = 2'd3;
        tick();
        chk("n3.sel3.ch", {6'd0, ch3}, 8'd2);
        chk("n3.sel3.strobe", {7'd0, strobe3}, 8'd0);
        chk("n3.sel3.dout", dout3, 8'h33);

        // Auto scan from reset: advances at edges 16, 32, 48, 64 after release.
        rst_n = 1'b0;
        mode  = 1'b1;
        hold  = 1'b0;
        din   = 32'h44332211;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step_chk($sformatf("auto.e%0d", k), 2'((k / 16) % 4), (k % 16) == 0);
        end

        // Reach cnt=10 on channel 0, then hold for 20 cycles.
        for (int k = 0; k < 10; k++) step_chk("pre_hold", 2'd0, 1'b0);
        hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 8) din = 32'h443322EE;
            step_chk($sformatf("hold.c%0d", k), 2'd0, 1'b0);
        end
        hold = 1'b0;
        for (int k = 1; k <= 5; k++) step_chk("post_hold", 2'd0, 1'b0);
        step_chk("hold_adv", 2'd1, 1'b1);

        // Run to ch=3 with cnt=15: 15 more on ch1, 16 on ch2, 15 on ch3.
        din = 32'h44332211;
        for (int k = 0; k < 15; k++) step_chk("run1", 2'd1, 1'b0);
        step_chk("run_adv2", 2'd2, 1'b1);
        for (int k = 0; k < 15; k++) step_chk("run2", 2'd2, 1'b0);
        step_chk("run_adv3", 2'd3, 1'b1);
        for (int k = 0; k < 15; k++) step_chk("run3", 2'd3, 1'b0);

        // Switch to manual at terminal count: sel wins over the auto wrap.
        mode = 1'b0;
        sel  = 2'd1;
        step_chk("to_manual", 2'd1, 1'b1);
        mode = 1'b1;
        for (int k = 0; k < 15; k++) step_chk("reauto", 2'd1, 1'b0);
        step_chk("reauto_adv", 2'd2, 1'b1);

        // Manual switch 0 -> 3: blank build shows 0 in the strobe cycle.
        mode = 1'b0;
        sel  = 2'd0;
        step_chk("blank.sel0", 2'd0, 1'b1);
        sel = 2'd3;
        step_chk("blank.sel3", 2'd3, 1'b1);
        step_chk("blank.after", 2'd3, 1'b0);
        chk("blank.after.value", dout, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
